// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern decoder.
// Holds the mode encoding, the default enable code and the one-hot LED helper.
package led_pattern_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned N_OUT = 1 << SEL_W;

  localparam logic [2:0] DEFAULT_ENABLE_CODE = 3'b100;

  typedef enum logic [1:0] {
    MODE_DECODE,
    MODE_CHASE,
    MODE_BLINK,
    MODE_BOUNCE
  } led_mode_t;

  // Active-low one-hot: only the LED at pos is driven low.
  function automatic logic [N_OUT-1:0] led_onehot_n(input logic [SEL_W-1:0] pos);
    return ~(N_OUT'(1) << pos);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler: counts open cycles and fires once every 2**DIV_W of them.
// Holds its count while not running so a paused pattern resumes in phase.
module led_tick_gen #(
  parameter int unsigned DIV_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = run & ~clear & (&div_cnt);

endmodule

// File: rtl/led_pattern_decoder.sv
// Gated 3-to-8 active-low LED decoder with timed chase, blink and bounce patterns.
// The LED bank is registered from next-state, so a state change shows on led at the same edge.
module led_pattern_decoder
  import led_pattern_pkg::*;
#(
  parameter int unsigned DIV_W       = 4,
  parameter logic [2:0]  ENABLE_CODE = DEFAULT_ENABLE_CODE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       enable,
  input  logic [SEL_W-1:0] switch,
  input  logic [1:0]       mode,
  output logic [N_OUT-1:0] led
);

  localparam logic [SEL_W-1:0] POS_MAX = '1;
  localparam logic             DIR_UP  = 1'b1;
  localparam logic             DIR_DN  = 1'b0;

  led_mode_t        mode_in;
  led_mode_t        mode_q, mode_d;
  logic [SEL_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             phase_q, phase_d;
  logic [N_OUT-1:0] led_d;
  logic             gate_open;
  logic             entry;
  logic             tick;

  assign mode_in   = led_mode_t'(mode);
  assign gate_open = (enable == ENABLE_CODE);
  assign entry     = gate_open && (mode_in != mode_q);

  led_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (gate_open & ~entry),
    .clear (entry),
    .tick  (tick)
  );

  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    led_d   = '1;
    if (gate_open) begin
      if (entry) begin
        pos_d   = switch;
        dir_d   = DIR_UP;
        phase_d = 1'b1;
        mode_d  = mode_in;
      end else begin
        unique case (mode_q)
          MODE_DECODE: pos_d = switch;
          MODE_CHASE: begin
            if (tick) pos_d = pos_q + SEL_W'(1);
          end
          MODE_BLINK: begin
            pos_d = switch;
            if (tick) phase_d = ~phase_q;
          end
          MODE_BOUNCE: begin
            // Turnarounds step straight to the neighbour so each end LED gets one tick period.
            if (tick) begin
              if (dir_q == DIR_UP) begin
                if (pos_q == POS_MAX) begin
                  pos_d = POS_MAX - SEL_W'(1);
                  dir_d = DIR_DN;
                end else begin
                  pos_d = pos_q + SEL_W'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  pos_d = SEL_W'(1);
                  dir_d = DIR_UP;
                end else begin
                  pos_d = pos_q - SEL_W'(1);
                end
              end
            end
          end
          default: pos_d = switch;
        endcase
      end
      led_d = (mode_d == MODE_BLINK && !phase_d) ? '1 : led_onehot_n(pos_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      phase_q <= 1'b1;
      mode_q  <= MODE_DECODE;
      led     <= '1;
    end else begin
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      led     <= led_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_decoder.sv
// Self-checking bench for led_pattern_decoder with a fast prescaler (tick every 4 open cycles).
// A behavioural model queues the expected LED word per cycle; tasks pop and compare after each edge.
module tb_led_pattern_decoder;

  logic       clk;
  logic       rst_n;
  logic [2:0] enable;
  logic [2:0] switch;
  logic [1:0] mode;
  logic [7:0] led;

  int checks;
  int failures;

  logic [7:0] sb[$];
  logic [7:0] exp_led;

  // Reference model state
  int m_pos;
  int m_div;
  int m_mode;
  bit m_up;
  bit m_phase;

  led_pattern_decoder #(
    .DIV_W       (2),
    .ENABLE_CODE (3'b100)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .switch (switch),
    .mode   (mode),
    .led    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pos = 0; m_div = 0; m_mode = 0; m_up = 1'b1; m_phase = 1'b1;
    sb.delete();
  endtask

  // Drive one cycle of inputs, queue the model's expectation and step past the edge.
  task automatic step(input logic [2:0] en, input logic [2:0] sw, input logic [1:0] md);
    logic [7:0] e;
    bit tk;
    enable = en; switch = sw; mode = md;
    if (en != 3'b100) begin
      e = 8'hFF;
    end else begin
      if (int'(md) != m_mode) begin
        m_pos = int'(sw); m_div = 0; m_up = 1'b1; m_phase = 1'b1; m_mode = int'(md);
      end else begin
        tk = (m_div == 3);
        m_div = (m_div + 1) % 4;
        case (m_mode)
          0: m_pos = int'(sw);
          1: if (tk) m_pos = (m_pos + 1) % 8;
          2: begin
            m_pos = int'(sw);
            if (tk) m_phase = !m_phase;
          end
          default: begin
            if (tk) begin
              if (m_up) begin
                if (m_pos == 7) begin m_pos = 6; m_up = 1'b0; end
                else m_pos = m_pos + 1;
              end else begin
                if (m_pos == 0) begin m_pos = 1; m_up = 1'b1; end
                else m_pos = m_pos - 1;
              end
            end
          end
        endcase
      end
      e = (m_mode == 2 && !m_phase) ? 8'hFF : (8'hFF ^ (8'h01 << m_pos));
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 3'b100; switch = 3'd3; mode = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (led !== 8'hFF) begin
      failures++; $display("FAIL reset_hold led=%h expected=%h", led, 8'hFF);
    end
    rst_n = 1'b1;
    step(3'b100, 3'd3, 2'd0);
    exp_led = sb.pop_front();
    checks++;
    if (led !== exp_led || led !== 8'hF7) begin
      failures++; $display("FAIL reset_first_edge led=%h expected=%h", led, 8'hF7);
    end
  endtask

  task automatic test_decode();
    step(3'b100, 3'd5, 2'd0);
    exp_led = sb.pop_front();
    checks++;
    if (led !== exp_led || led !== 8'hDF) begin
      failures++; $display("FAIL decode_sw5 led=%h expected=%h", led, 8'hDF);
    end
    step(3'b110, 3'd5, 2'd0);
    exp_led = sb.pop_front();
    checks++;
    if (led !== exp_led || led !== 8'hFF) begin
      failures++; $display("FAIL decode_gate_closed led=%h expected=%h", led, 8'hFF);
    end
    for (int en = 0; en < 8; en++) begin
      for (int sw = 0; sw < 8; sw++) begin
        step(3'(en), 3'(sw), 2'd0);
        exp_led = sb.pop_front();
        checks++;
        if (led !== exp_led) begin
          failures++;
          $display("FAIL decode_sweep en=%0d sw=%0d led=%h expected=%h", en, sw, led, exp_led);
        end
      end
    end
  endtask

  task automatic test_chase();
    logic [7:0] lit[9] = '{8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFE};
    for (int k = 0; k < 9; k++) begin
      step(3'b100, 3'd6, 2'd1);
      exp_led = sb.pop_front();
      checks++;
      if (led !== exp_led || led !== lit[k]) begin
        failures++; $display("FAIL chase_step%0d led=%h expected=%h", k, led, lit[k]);
      end
    end
  endtask

  task automatic test_bounce();
    int top_cycles;
    top_cycles = 0;
    for (int k = 0; k < 48; k++) begin
      step(3'b100, 3'd6, 2'd3);
      exp_led = sb.pop_front();
      checks++;
      if (led !== exp_led) begin
        failures++; $display("FAIL bounce_step%0d led=%h expected=%h", k, led, exp_led);
      end
      if (k == 0 && led !== 8'hBF) begin
        failures++; $display("FAIL bounce_entry led=%h expected=%h", led, 8'hBF);
      end
      if (k == 4 && led !== 8'h7F) begin
        failures++; $display("FAIL bounce_top led=%h expected=%h", led, 8'h7F);
      end
      if (k == 8 && led !== 8'hBF) begin
        failures++; $display("FAIL bounce_turn led=%h expected=%h", led, 8'hBF);
      end
      if (k == 12 && led !== 8'hDF) begin
        failures++; $display("FAIL bounce_down led=%h expected=%h", led, 8'hDF);
      end
      if (k < 16 && led === 8'h7F) top_cycles++;
    end
    checks++;
    if (top_cycles != 4) begin
      failures++; $display("FAIL bounce_top_duration cycles=%0d expected=4", top_cycles);
    end
  endtask

  task automatic test_blink();
    logic [7:0] lit[13] = '{8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                            8'hFB, 8'hEF, 8'hEF, 8'hEF, 8'hFF};
    for (int k = 0; k < 13; k++) begin
      step(3'b100, (k < 9) ? 3'd2 : 3'd4, 2'd2);
      exp_led = sb.pop_front();
      checks++;
      if (led !== exp_led || led !== lit[k]) begin
        failures++; $display("FAIL blink_step%0d led=%h expected=%h", k, led, lit[k]);
      end
    end
  endtask

  task automatic test_gate_resume();
    logic [7:0] lit[15] = '{8'hF7, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                            8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF7, 8'hF7, 8'hEF};
    for (int k = 0; k < 15; k++) begin
      step((k >= 2 && k < 12) ? 3'b000 : 3'b100, 3'd3, 2'd1);
      exp_led = sb.pop_front();
      checks++;
      if (led !== exp_led || led !== lit[k]) begin
        failures++; $display("FAIL resume_step%0d led=%h expected=%h", k, led, lit[k]);
      end
    end
  endtask

  task automatic test_mode_change_closed();
    step(3'b101, 3'd1, 2'd0);
    step(3'b101, 3'd1, 2'd2);
    step(3'b100, 3'd1, 2'd2);
    for (int k = 0; k < 3; k++) begin
      exp_led = sb.pop_front();
      checks++;
      if (led === 8'h00 || (k == 2 && led !== exp_led)) begin
        failures++; $display("FAIL closed_mode_change%0d led=%h expected=%h", k, led, exp_led);
      end
    end
    checks++;
    if (led !== 8'hFD) begin
      failures++; $display("FAIL closed_mode_entry led=%h expected=%h", led, 8'hFD);
    end
  endtask

  task automatic test_reset_mid_chase();
    for (int k = 0; k < 6; k++) begin
      step(3'b100, 3'd0, 2'd1);
      exp_led = sb.pop_front();
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 8'hFF) begin
      failures++; $display("FAIL reset_async led=%h expected=%h", led, 8'hFF);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3'b100, 3'd3, 2'd0);
    exp_led = sb.pop_front();
    checks++;
    if (led !== exp_led || led !== 8'hF7) begin
      failures++; $display("FAIL reset_release led=%h expected=%h", led, 8'hF7);
    end
  endtask

  task automatic test_random();
    logic [2:0] en;
    for (int k = 0; k < 300; k++) begin
      en = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b100;
      step(en, 3'($urandom_range(0, 7)),
           ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_mode));
      exp_led = sb.pop_front();
      checks++;
      if (led !== exp_led) begin
        failures++; $display("FAIL random_step%0d led=%h expected=%h", k, led, exp_led);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_decode();
    test_chase();
    test_bounce();
    test_blink();
    test_gate_resume();
    test_mode_change_closed();
    test_reset_mid_chase();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
